// File: rtl/mips_control.sv
// Multicycle MIPS control unit: Moore FSM driving datapath selects and strobes,
// plus a retired-instruction counter.
module mips_control #(
   parameter bit ILLEGAL_TRAP = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic        flagZ,
   output logic [2:0]  alu_selector,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  pc_src,
   output logic        pc_write,
   output logic        ir_write,
   output logic        mem_write,
   output logic        reg_write,
   output logic        iord,
   output logic        mem_to_reg,
   output logic        reg_dst,
   output logic [3:0]  state,
   output logic        halted,
   output logic [31:0] instret
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTE  = 4'd6,
      S_ALUWB    = 4'd7,
      S_BRANCH   = 4'd8,
      S_ADDIEXEC = 4'd9,
      S_ADDIWB   = 4'd10,
      S_JUMP     = 4'd11,
      S_HALT     = 4'd12
   } state_t;

   state_t      state_q, state_d;
   logic        is_sw_q, is_sw_d;
   logic [31:0] instret_q, instret_d;
   logic        retire;

   // lw/sw choice is captured in DECODE so opcode is not looked at again in MEMADR.
   always_comb begin
      state_d = S_FETCH;
      is_sw_d = is_sw_q;
      case (state_q)
         S_FETCH:    state_d = S_DECODE;
         S_DECODE: begin
            is_sw_d = (opcode == 6'b101011);
            case (opcode)
               6'b000000:            state_d = S_EXECUTE;
               6'b100011, 6'b101011: state_d = S_MEMADR;
               6'b000100:            state_d = S_BRANCH;
               6'b001000:            state_d = S_ADDIEXEC;
               6'b000010:            state_d = S_JUMP;
               default:              state_d = ILLEGAL_TRAP ? S_HALT : S_FETCH;
            endcase
         end
         S_MEMADR:   state_d = is_sw_q ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  state_d = S_MEMWB;
         S_EXECUTE:  state_d = S_ALUWB;
         S_ADDIEXEC: state_d = S_ADDIWB;
         S_HALT:     state_d = S_HALT;
         default:    state_d = S_FETCH;
      endcase
   end

   always_comb begin
      retire = 1'b0;
      case (state_q)
         S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: retire = 1'b1;
         default: retire = 1'b0;
      endcase
   end

   assign instret_d = retire ? instret_q + 32'd1 : instret_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_FETCH;
         is_sw_q   <= 1'b0;
         instret_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         is_sw_q   <= is_sw_d;
         instret_q <= instret_d;
      end
   end

   // Moore decode from the registered state; only BRANCH looks at flagZ.
   always_comb begin
      alu_selector = 3'b000;
      alu_src_a    = 1'b0;
      alu_src_b    = 2'b00;
      pc_src       = 2'b00;
      pc_write     = 1'b0;
      ir_write     = 1'b0;
      mem_write    = 1'b0;
      reg_write    = 1'b0;
      iord         = 1'b0;
      mem_to_reg   = 1'b0;
      reg_dst      = 1'b0;
      case (state_q)
         S_FETCH: begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            alu_src_b = 2'b01;
         end
         S_DECODE:   alu_src_b = 2'b11;
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEMREAD:  iord = 1'b1;
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEMWRITE: begin
            iord      = 1'b1;
            mem_write = 1'b1;
         end
         S_EXECUTE: begin
            alu_src_a = 1'b1;
            case (funct)
               6'b100000: alu_selector = 3'b000;
               6'b100010: alu_selector = 3'b001;
               6'b100100: alu_selector = 3'b010;
               6'b100101: alu_selector = 3'b011;
               6'b100110: alu_selector = 3'b100;
               default:   alu_selector = 3'b101;
            endcase
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a    = 1'b1;
            alu_selector = 3'b001;
            pc_src       = 2'b01;
            pc_write     = flagZ;
         end
         S_ADDIEXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_ADDIWB:   reg_write = 1'b1;
         S_JUMP: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
         end
         default: ;
      endcase
   end

   assign state   = state_q;
   assign halted  = (state_q == S_HALT);
   assign instret = instret_q;

endmodule

// File: tb/tb_mips_control.sv
// Random instruction streams against a path-and-table model of the control unit,
// for both illegal-opcode policies, plus reset, halt and counter-wrap scenarios.
module tb_mips_control;

   localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMREAD = 3, MEMWB = 4,
                  MEMWRITE = 5, EXECUTE = 6, ALUWB = 7, BRANCH = 8,
                  ADDIEXEC = 9, ADDIWB = 10, JUMP = 11, HALT = 12;
   localparam int K_LW = 0, K_SW = 1, K_R = 2, K_ADDI = 3, K_BEQ = 4, K_J = 5, K_ILL = 6;

   logic        clk = 1'b0;
   logic        reset_a = 1'b1, reset_b = 1'b1;
   logic [5:0]  opcode = '0, funct = '0;
   logic        flagZ = 1'b0;

   logic [2:0]  alu_selector_a, alu_selector_b;
   logic        alu_src_a_a, alu_src_a_b;
   logic [1:0]  alu_src_b_a, alu_src_b_b, pc_src_a, pc_src_b;
   logic        pc_write_a, ir_write_a, mem_write_a, reg_write_a, iord_a, mem_to_reg_a, reg_dst_a, halted_a;
   logic        pc_write_b, ir_write_b, mem_write_b, reg_write_b, iord_b, mem_to_reg_b, reg_dst_b, halted_b;
   logic [3:0]  state_a, state_b;
   logic [31:0] instret_a, instret_b;

   int n_checks = 0;
   int n_err    = 0;
   bit use_b    = 1'b0;
   logic [31:0] model_instret = '0;

   always #5 clk = ~clk;

   mips_control #(.ILLEGAL_TRAP(1'b1)) dut_a (
      .clk(clk), .reset(reset_a), .opcode(opcode), .funct(funct), .flagZ(flagZ),
      .alu_selector(alu_selector_a), .alu_src_a(alu_src_a_a), .alu_src_b(alu_src_b_a),
      .pc_src(pc_src_a), .pc_write(pc_write_a), .ir_write(ir_write_a), .mem_write(mem_write_a),
      .reg_write(reg_write_a), .iord(iord_a), .mem_to_reg(mem_to_reg_a), .reg_dst(reg_dst_a),
      .state(state_a), .halted(halted_a), .instret(instret_a));

   mips_control #(.ILLEGAL_TRAP(1'b0)) dut_b (
      .clk(clk), .reset(reset_b), .opcode(opcode), .funct(funct), .flagZ(flagZ),
      .alu_selector(alu_selector_b), .alu_src_a(alu_src_a_b), .alu_src_b(alu_src_b_b),
      .pc_src(pc_src_b), .pc_write(pc_write_b), .ir_write(ir_write_b), .mem_write(mem_write_b),
      .reg_write(reg_write_b), .iord(iord_b), .mem_to_reg(mem_to_reg_b), .reg_dst(reg_dst_b),
      .state(state_b), .halted(halted_b), .instret(instret_b));

   // {alu_selector, alu_src_a, alu_src_b, pc_src, pc_write, ir_write, mem_write,
   //  reg_write, iord, mem_to_reg, reg_dst, halted}
   logic [15:0] obs_a, obs_b;
   assign obs_a = {alu_selector_a, alu_src_a_a, alu_src_b_a, pc_src_a, pc_write_a, ir_write_a,
                   mem_write_a, reg_write_a, iord_a, mem_to_reg_a, reg_dst_a, halted_a};
   assign obs_b = {alu_selector_b, alu_src_a_b, alu_src_b_b, pc_src_b, pc_write_b, ir_write_b,
                   mem_write_b, reg_write_b, iord_b, mem_to_reg_b, reg_dst_b, halted_b};

   function automatic logic [15:0] obs_out();
      return use_b ? obs_b : obs_a;
   endfunction
   function automatic logic [31:0] obs_state();
      return {28'd0, (use_b ? state_b : state_a)};
   endfunction
   function automatic logic [31:0] obs_instret();
      return use_b ? instret_b : instret_a;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Expected outputs for a state, straight from the per-state output list.
   function automatic logic [15:0] exp_out(input int st, input logic [5:0] fn, input logic fz);
      logic [2:0] sel = 3'b000;
      logic       a = 1'b0;
      logic [1:0] b = 2'b00, ps = 2'b00;
      logic pcw = 0, irw = 0, mw = 0, rw = 0, io = 0, m2r = 0, rd = 0, h = 0;
      case (st)
         FETCH:    begin irw = 1; pcw = 1; b = 2'b01; end
         DECODE:   b = 2'b11;
         MEMADR:   begin a = 1; b = 2'b10; end
         MEMREAD:  io = 1;
         MEMWB:    begin rw = 1; m2r = 1; end
         MEMWRITE: begin io = 1; mw = 1; end
         EXECUTE: begin
            a = 1;
            if (fn == 6'h20)      sel = 3'd0;
            else if (fn == 6'h22) sel = 3'd1;
            else if (fn == 6'h24) sel = 3'd2;
            else if (fn == 6'h25) sel = 3'd3;
            else if (fn == 6'h26) sel = 3'd4;
            else                  sel = 3'd5;
         end
         ALUWB:    begin rw = 1; rd = 1; end
         BRANCH:   begin a = 1; sel = 3'd1; ps = 2'b01; pcw = fz; end
         ADDIEXEC: begin a = 1; b = 2'b10; end
         ADDIWB:   rw = 1;
         JUMP:     begin pcw = 1; ps = 2'b10; end
         HALT:     h = 1;
         default: ;
      endcase
      return {sel, a, b, ps, pcw, irw, mw, rw, io, m2r, rd, h};
   endfunction

   function automatic bit is_legal(input logic [5:0] op);
      return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h08 || op == 6'h02;
   endfunction

   // Called at a falling edge with the DUT in FETCH; returns at the falling edge
   // after the instruction (or after DECODE for an illegal opcode).
   task automatic run_instr(input int kind, input logic [5:0] fn, input int fz);
      int path[$];
      logic [5:0] op;
      logic z;
      case (kind)
         K_LW:   begin op = 6'h23; path = '{FETCH, DECODE, MEMADR, MEMREAD, MEMWB}; end
         K_SW:   begin op = 6'h2B; path = '{FETCH, DECODE, MEMADR, MEMWRITE}; end
         K_R:    begin op = 6'h00; path = '{FETCH, DECODE, EXECUTE, ALUWB}; end
         K_ADDI: begin op = 6'h08; path = '{FETCH, DECODE, ADDIEXEC, ADDIWB}; end
         K_BEQ:  begin op = 6'h04; path = '{FETCH, DECODE, BRANCH}; end
         K_J:    begin op = 6'h02; path = '{FETCH, DECODE, JUMP}; end
         default: begin
            do op = 6'($urandom_range(0, 63)); while (is_legal(op));
            path = '{FETCH, DECODE};
         end
      endcase
      for (int i = 0; i < path.size(); i++) begin
         if (i > 0) @(negedge clk);
         opcode = (path[i] == DECODE)  ? op : 6'($urandom_range(0, 63));
         funct  = (path[i] == EXECUTE) ? fn : 6'($urandom_range(0, 63));
         z      = (fz < 0) ? 1'($urandom_range(0, 1)) : 1'(fz);
         flagZ  = z;
         #1;
         check($sformatf("state k%0d s%0d", kind, i), obs_state(), 32'(path[i]));
         check($sformatf("outs k%0d st%0d", kind, path[i]), 32'(obs_out()), 32'(exp_out(path[i], fn, z)));
         if (i == 0) check("instret", obs_instret(), model_instret);
      end
      if (kind != K_ILL) model_instret = model_instret + 32'd1;
      @(negedge clk);
   endtask

   // Resets the selected DUT; the other is held in reset. Returns at a falling edge in FETCH.
   task automatic do_reset(input bit b);
      @(negedge clk);
      use_b = b;
      reset_a = 1'b1;
      reset_b = 1'b1;
      #1;
      model_instret = '0;
      check("rst state", obs_state(), 32'(FETCH));
      check("rst outs", 32'(obs_out()), 32'(exp_out(FETCH, 6'd0, 1'b0)));
      check("rst instret", obs_instret(), model_instret);
      @(negedge clk);
      if (b) reset_b = 1'b0; else reset_a = 1'b0;
   endtask

   function automatic logic [5:0] rand_funct();
      logic [5:0] tbl [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26};
      if ($urandom_range(0, 3) == 0) return 6'($urandom_range(0, 63));
      return tbl[$urandom_range(0, 4)];
   endfunction

   initial begin
      do_reset(1'b0);

      // directed cases on the trapping instance
      run_instr(K_LW, 6'd0, -1);
      run_instr(K_R, 6'h22, -1);
      run_instr(K_R, 6'h3F, -1);
      run_instr(K_BEQ, 6'd0, 1);
      run_instr(K_BEQ, 6'd0, 0);
      for (int n = 0; n < 40; n++)
         run_instr($urandom_range(K_LW, K_J), rand_funct(), -1);

      // async reset while in MEMREAD
      opcode = 6'h23;
      @(negedge clk); opcode = 6'h23;
      @(negedge clk); opcode = 6'($urandom_range(0, 63));
      @(negedge clk); #1;
      check("pre-abort state", obs_state(), 32'(MEMREAD));
      #1 reset_a = 1'b1;
      #1;
      model_instret = '0;
      check("abort state", obs_state(), 32'(FETCH));
      check("abort instret", obs_instret(), model_instret);
      @(negedge clk); reset_a = 1'b0;
      run_instr(K_SW, 6'd0, -1);

      // illegal opcode traps into HALT
      run_instr(K_ILL, 6'd0, -1);
      for (int c = 0; c < 10; c++) begin
         opcode = 6'($urandom_range(0, 63));
         flagZ  = 1'($urandom_range(0, 1));
         #1;
         check("halt state", obs_state(), 32'(HALT));
         check("halt outs", 32'(obs_out()), 32'(exp_out(HALT, 6'd0, 1'b0)));
         check("halt instret", obs_instret(), model_instret);
         @(negedge clk);
      end

      // counter wrap
      do_reset(1'b0);
      force dut_a.instret_q = 32'hFFFF_FFFF;
      #1 release dut_a.instret_q;
      model_instret = 32'hFFFF_FFFF;
      run_instr(K_J, 6'd0, -1);
      #1 check("wrap instret", obs_instret(), model_instret);

      // non-trapping instance: illegal opcodes return to FETCH without retiring
      do_reset(1'b1);
      run_instr(K_ILL, 6'd0, -1);
      for (int n = 0; n < 30; n++)
         run_instr($urandom_range(K_LW, K_ILL), rand_funct(), -1);
      #1 check("final instret", obs_instret(), model_instret);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
